bitwise_seq: RTL and testbench

- Parametrised successor to the team's 4-register bitwise instruction unit.
- Self-contained register file of NREG registers, each W bits wide, plus a tmp register and a multi-cycle FSM.
- Executes one instruction per start pulse using an s/done handshake.
- Adds AND, OR and variable-count ROL, selectable operand registers, an illegal-op flag and a register read-back port.

---
 rtl/bitwise_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_bitwise_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_seq.sv
// bitwise_seq: multi-cycle bitwise instruction unit with a private register file.
//
// Holds NREG registers of W bits plus a tmp register. One instruction runs per
// accepted start (s high while done is high). Opcodes: 0 MOV, 1 XOR, 2 AND, 3 OR,
// 4 ASL, 5 SWP, 6 ROL. Opcodes 7..15 are illegal: they raise err and leave
// all state untouched.
//
// Optional feature: define BITWISE_SEQ_CNT_EN to add icount[15:0]. It counts
// completed legal instructions and wraps from 16'hFFFF to 0.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   reset  in   synchronous active-high reset
//   s      in   start, sampled only while done is high
//   op     in   [3:0] opcode, latched at start
//   ra     in   [AW-1:0] first operand index (Ri for MOV/SWP), latched at start
//   rb     in   [AW-1:0] second operand index, latched at start
//   in     in   [W-1:0] immediate for MOV, latched at start
//   rsel   in   [AW-1:0] read-back select (not latched)
//   out    out  [W-1:0] combinational R[rsel]
//   done   out  high only when idle (WAIT)
//   err    out  registered illegal-op flag
//   icount out  [15:0] completed-instruction count (BITWISE_SEQ_CNT_EN only)
module bitwise_seq #(
  parameter int W = 8,
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [3:0]    op,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [W-1:0]  in,
  input  logic [AW-1:0] rsel,
  output logic [W-1:0]  out,
  output logic          done,
  output logic          err
`ifdef BITWISE_SEQ_CNT_EN
  ,
  output logic [15:0]   icount
`endif
);

  localparam int KW = $clog2(W);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_ASL = 4'd4;
  localparam logic [3:0] OP_SWP = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;

  typedef enum logic [3:0] {
    S_WAIT = 4'd0,
    S_MOV  = 4'd1,
    S_LOAD = 4'd2,
    S_EXEC = 4'd3,
    S_SHL  = 4'd4,
    S_ROT  = 4'd5,
    S_WB   = 4'd6,
    S_SWP1 = 4'd7,
    S_SWP2 = 4'd8,
    S_SWP3 = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  regs_q [NREG];
  logic [W-1:0]  regs_d [NREG];
  logic [W-1:0]  tmp_q, tmp_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] rb_q, rb_d;
  logic [W-1:0]  in_q, in_d;
  logic          err_q, err_d;

  // Single write port into the register file.
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;

  logic [W-1:0]  rd_a;
  logic [W-1:0]  rd_b;
  logic          op_legal;

  // Operands come from the live register values in the cycle they are used.
  assign rd_a     = regs_q[ra_q];
  assign rd_b     = regs_q[rb_q];
  assign op_legal = (op <= OP_ROL);

  assign out  = regs_q[rsel];
  assign done = (state_q == S_WAIT);
  assign err  = err_q;

  always_comb begin
    state_d = state_q;
    tmp_d   = tmp_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    in_d    = in_q;
    err_d   = err_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;

    case (state_q)
      S_WAIT: begin
        if (s) begin
          if (op_legal) begin
            op_d  = op;
            ra_d  = ra;
            rb_d  = rb;
            in_d  = in;
            err_d = 1'b0;
            case (op)
              OP_MOV:  state_d = S_MOV;
              OP_SWP:  state_d = S_SWP1;
              default: state_d = S_LOAD;
            endcase
          end else begin
            // Illegal opcode: flag it and stay idle.
            err_d = 1'b1;
          end
        end
      end
      S_MOV: begin
        we      = 1'b1;
        waddr   = ra_q;
        wdata   = in_q;
        state_d = S_WAIT;
      end
      S_LOAD: begin
        tmp_d = rd_a;
        if (op_q == OP_ROL) begin
          // Rotate count uses only the low log2(W) bits, so k==W acts as k==0.
          cnt_d   = rd_b[KW-1:0];
          state_d = (rd_b[KW-1:0] == '0) ? S_WB : S_ROT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_XOR:  tmp_d = tmp_q ^ rd_b;
          OP_OR:   tmp_d = tmp_q | rd_b;
          default: tmp_d = tmp_q & rd_b;   // AND and the AND step of ASL
        endcase
        state_d = (op_q == OP_ASL) ? S_SHL : S_WB;
      end
      S_SHL: begin
        tmp_d   = {tmp_q[W-2:0], 1'b0};
        state_d = S_WB;
      end
      S_ROT: begin
        tmp_d = {tmp_q[W-2:0], tmp_q[W-1]};
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        we      = 1'b1;
        waddr   = '0;
        wdata   = tmp_q;
        state_d = S_WAIT;
      end
      S_SWP1: begin
        tmp_d   = regs_q[0];
        state_d = S_SWP2;
      end
      S_SWP2: begin
        we      = 1'b1;
        waddr   = '0;
        wdata   = rd_a;
        state_d = S_SWP3;
      end
      S_SWP3: begin
        // With ra==0 this writes the original R0 back, leaving R0 unchanged.
        we      = 1'b1;
        waddr   = ra_q;
        wdata   = tmp_q;
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // Per-register next value from the single write port.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg_next
      assign regs_d[gi] = (we && (waddr == AW'(gi))) ? wdata : regs_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      tmp_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      in_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      in_q    <= in_d;
      err_q   <= err_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef BITWISE_SEQ_CNT_EN
  logic [15:0] icount_q, icount_d;
  logic        fin;

  // These three states are the last cycle of a legal instruction; their edge
  // is the final write edge.
  assign fin      = (state_q == S_MOV) || (state_q == S_WB) || (state_q == S_SWP3);
  assign icount_d = fin ? icount_q + 16'd1 : icount_q;
  assign icount   = icount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      icount_q <= '0;
    end else begin
      icount_q <= icount_d;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_seq.sv
module tb_bitwise_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] in_v;
  logic [1:0] rsel;
  logic [7:0] out;
  logic       done;
  logic       err;
`ifdef BITWISE_SEQ_CNT_EN
  logic [15:0] icount;
`endif

  bitwise_seq #(.W(8), .NREG(4)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .op    (op),
    .ra    (ra),
    .rb    (rb),
    .in    (in_v),
    .rsel  (rsel),
    .out   (out),
    .done  (done),
    .err   (err)
`ifdef BITWISE_SEQ_CNT_EN
    ,
    .icount(icount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         lat;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got done=0 after 40 cycles expected done=1", nm);
    end
  endtask

  // Issue one legal instruction; the scoreboard entry holds the expected
  // done-low cycle count and the expected R[rs] value at completion.
  task automatic issue(input string nm, input logic [3:0] o, input logic [1:0] a,
                       input logic [1:0] b, input logic [7:0] im, input logic [1:0] rs,
                       input int lat, input logic [7:0] ev, input bit glitch);
    exp_t e;
    e.name = nm;
    e.lat  = lat;
    e.val  = ev;
    @(posedge clk); #1;
    op = o; ra = a; rb = b; in_v = im; rsel = rs; s = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    s = 1'b0;
    if (glitch) begin
      // A MOV R1=FF start while busy must be ignored.
      @(posedge clk); #1;
      s = 1'b1; op = 4'd0; ra = 2'd1; in_v = 8'hFF;
      @(posedge clk); #1;
      s = 1'b0;
    end
    wait_done(nm);
  endtask

  task automatic illegal(input logic [1:0] rs, input logic [7:0] ev);
    @(posedge clk); #1;
    op = 4'hF; rsel = rs; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    @(negedge clk);
    chk("illegal_err", err, 1'b1);
    chk("illegal_done", done, 1'b1);
    chk("illegal_nochange", out, ev);
    repeat (2) begin
      @(negedge clk);
      chk("illegal_done_hold", done, 1'b1);
    end
  endtask

  task automatic check_reg(input logic [1:0] idx, input logic [7:0] ev, input string nm);
    @(posedge clk); #1;
    rsel = idx;
    @(negedge clk);
    chk(nm, out, ev);
    $display("read R%0d=%0h", idx, out);
  endtask

  // Monitor: counts done-low cycles and checks each completion against the
  // oldest scoreboard entry.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (done === 1'b0) begin
        run++;
      end else if (run > 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_completion: got run=%0d expected no instruction", run);
        end else begin
          e = sb.pop_front();
          $display("txn %s lat=%0d out=%0h err=%0b", e.name, run, out, err);
          chk({e.name, "_lat"}, run, e.lat);
          chk({e.name, "_out"}, out, e.val);
          chk({e.name, "_err"}, err, 1'b0);
        end
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; s = 1'b0; op = '0; ra = '0; rb = '0; in_v = '0; rsel = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_done", done, 1'b1);
    chk("reset_out", out, 8'h00);
    chk("reset_err", err, 1'b0);
`ifdef BITWISE_SEQ_CNT_EN
    chk("reset_icount", icount, 16'd0);
`endif
    mon_en = 1;

    // MOV / XOR
    issue("mov_r1_a5", 4'd0, 2'd1, 2'd0, 8'hA5, 2'd1, 1, 8'hA5, 0);
    issue("mov_r2_0f", 4'd0, 2'd2, 2'd0, 8'h0F, 2'd2, 1, 8'h0F, 0);
    issue("xor_1_2",   4'd1, 2'd1, 2'd2, 8'h00, 2'd0, 3, 8'hAA, 0);
    // AND / OR with aliasing
    issue("and_1_2",   4'd2, 2'd1, 2'd2, 8'h00, 2'd0, 3, 8'h05, 0);
    issue("or_0_2",    4'd3, 2'd0, 2'd2, 8'h00, 2'd0, 3, 8'h0F, 0);
    // ASL
    issue("mov_r1_c3", 4'd0, 2'd1, 2'd0, 8'hC3, 2'd1, 1, 8'hC3, 0);
    issue("mov_r2_f0", 4'd0, 2'd2, 2'd0, 8'hF0, 2'd2, 1, 8'hF0, 0);
    issue("asl_1_2",   4'd4, 2'd1, 2'd2, 8'h00, 2'd0, 4, 8'h80, 0);
    // ROL
    issue("mov_r1_81", 4'd0, 2'd1, 2'd0, 8'h81, 2'd1, 1, 8'h81, 0);
    issue("mov_r3_03", 4'd0, 2'd3, 2'd0, 8'h03, 2'd3, 1, 8'h03, 0);
    issue("rol_k3",    4'd6, 2'd1, 2'd3, 8'h00, 2'd0, 5, 8'h0C, 0);
    issue("mov_r3_08", 4'd0, 2'd3, 2'd0, 8'h08, 2'd3, 1, 8'h08, 0);
    issue("rol_k0",    4'd6, 2'd1, 2'd3, 8'h00, 2'd0, 2, 8'h81, 0);
    // SWP
    issue("mov_r0_11", 4'd0, 2'd0, 2'd0, 8'h11, 2'd0, 1, 8'h11, 0);
    issue("mov_r2_22", 4'd0, 2'd2, 2'd0, 8'h22, 2'd2, 1, 8'h22, 0);
    issue("swp_r2",    4'd5, 2'd2, 2'd0, 8'h00, 2'd0, 3, 8'h22, 0);
    check_reg(2'd2, 8'h11, "swp_r2_value");
    issue("swp_r0",    4'd5, 2'd0, 2'd0, 8'h00, 2'd0, 3, 8'h22, 0);
    // Illegal op, then a MOV that must clear err (monitor checks err=0)
    illegal(2'd0, 8'h22);
    issue("mov_r3_5a", 4'd0, 2'd3, 2'd0, 8'h5A, 2'd3, 1, 8'h5A, 0);
    // Start pulsed mid-XOR: R0 = 81 ^ 11, R1 must stay 81
    issue("xor_glitch", 4'd1, 2'd1, 2'd2, 8'h00, 2'd0, 3, 8'h90, 1);
    check_reg(2'd1, 8'h81, "glitch_r1_kept");

    // Reset during SHL of an ASL: aborted after LOAD, EXEC, SHL
    begin
      exp_t e;
      e.name = "asl_abort"; e.lat = 3; e.val = 8'h00;
      @(posedge clk); #1;
      op = 4'd4; ra = 2'd1; rb = 2'd2; rsel = 2'd0; s = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1 s = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      wait_done("asl_abort");
    end
    for (int i = 0; i < 4; i++) begin
      check_reg(2'(i), 8'h00, "reset_clear_reg");
    end
    chk("abort_err", err, 1'b0);
`ifdef BITWISE_SEQ_CNT_EN
    chk("abort_icount", icount, 16'd0);
`endif

    // Five legal instructions plus one illegal one
    issue("cnt_mov_r1", 4'd0, 2'd1, 2'd0, 8'h01, 2'd1, 1, 8'h01, 0);
    issue("cnt_mov_r2", 4'd0, 2'd2, 2'd0, 8'h03, 2'd2, 1, 8'h03, 0);
    issue("cnt_xor",    4'd1, 2'd1, 2'd2, 8'h00, 2'd0, 3, 8'h02, 0);
    illegal(2'd0, 8'h02);
    issue("cnt_asl",    4'd4, 2'd1, 2'd2, 8'h00, 2'd0, 4, 8'h02, 0);
    issue("cnt_rol",    4'd6, 2'd1, 2'd2, 8'h00, 2'd0, 5, 8'h08, 0);
`ifdef BITWISE_SEQ_CNT_EN
    @(negedge clk);
    chk("icount_5", icount, 16'd5);
`endif

    @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
